// File: rtl/uart_rx_status.sv
// uart_rx_status: receive-side line status bits and RX interrupt requests.
// Tracks FIFO head errors, error-entry count and character-timeout idle time.
module uart_rx_status #(
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        enable,
    input  logic [7:0]  LCR,
    input  logic [1:0]  FCR_trig,
    input  logic [2:0]  IER,
    input  logic        push_rx_fifo,
    input  logic        pop_rx_fifo,
    input  logic [4:0]  rx_fifo_count,
    input  logic        rx_fifo_empty,
    input  logic        rx_fifo_full,
    input  logic [10:0] rx_fifo_out,
    input  logic        parity_error,
    input  logic        framing_error,
    input  logic        break_error,
    input  logic        rx_overrun,
    input  logic        rx_fifo_reset,
    input  logic        lsr_read,
    output logic        lsr_dr,
    output logic        lsr_oe,
    output logic        lsr_pe,
    output logic        lsr_fe,
    output logic        lsr_bi,
    output logic        lsr_fifo_err,
    output logic        rx_data_int,
    output logic        rx_timeout_int,
    output logic        rx_ls_int
);

    logic        head_new;
    logic [4:0]  err_cnt;
    logic [9:0]  tmo_cnt;
    logic [3:0]  frame_bits;
    logic [9:0]  tmo_limit;
    logic [4:0]  trig_lvl;
    logic        err_inc;
    logic        err_dec;
    logic        tmo_hit;
    logic        unused_ok;

    // Fields this block never looks at.
    assign unused_ok = ^{LCR[7:4], IER[1], rx_fifo_out[7:0]};

    // One character in bit times: start + data + parity + stop(s).
    always_comb begin
        frame_bits = 4'd7
                   + {2'b00, LCR[1:0]}
                   + {3'b000, LCR[3]}
                   + {3'b000, LCR[2]};
    end

    // Idle limit in enable ticks; follows LCR with no delay.
    always_comb begin
        tmo_limit = 10'(TIMEOUT_CHARS * 16) * {6'b0, frame_bits};
    end

    // RX trigger level decode.
    always_comb begin
        trig_lvl = 5'd1;
        unique case (FCR_trig)
            2'b00: trig_lvl = 5'd1;
            2'b01: trig_lvl = 5'd4;
            2'b10: trig_lvl = 5'd8;
            2'b11: trig_lvl = 5'd14;
        endcase
    end

    // Error-entry bookkeeping terms and the timeout match.
    always_comb begin
        err_inc = push_rx_fifo
                & (parity_error | framing_error | break_error)
                & ~rx_fifo_full;
        err_dec = pop_rx_fifo
                & (|rx_fifo_out[10:8])
                & (err_cnt != 5'd0);
        tmo_hit = (tmo_cnt == tmo_limit)
                & ~rx_fifo_empty
                & IER[0];
    end

    assign lsr_fifo_err = (err_cnt != 5'd0);

    // Data ready; a push looks ahead so DR rises one cycle after it.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            lsr_dr <= 1'b0;
        else if (rx_fifo_reset)
            lsr_dr <= 1'b0;
        else
            lsr_dr <= ~rx_fifo_empty | push_rx_fifo;
    end

    // Overrun is sticky until an LSR read; a new overrun beats the read.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            lsr_oe <= 1'b0;
        else if (push_rx_fifo && rx_overrun)
            lsr_oe <= 1'b1;
        else if (lsr_read)
            lsr_oe <= 1'b0;
    end

    // Flags a new entry arriving at the FIFO head.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            head_new <= 1'b0;
        else if (rx_fifo_reset)
            head_new <= 1'b0;
        else
            head_new <= (push_rx_fifo && rx_fifo_empty)
                     || (pop_rx_fifo && rx_fifo_count > 5'd1);
    end

    // Head error bits latch into the LSR; set beats a same-cycle read.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            lsr_pe <= 1'b0;
            lsr_fe <= 1'b0;
            lsr_bi <= 1'b0;
        end else begin
            lsr_pe <= (head_new & rx_fifo_out[9])
                    | (lsr_pe & ~lsr_read);
            lsr_fe <= (head_new & rx_fifo_out[8])
                    | (lsr_fe & ~lsr_read);
            lsr_bi <= (head_new & rx_fifo_out[10])
                    | (lsr_bi & ~lsr_read);
        end
    end

    // Count of erroneous entries held in the FIFO.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            err_cnt <= 5'd0;
        else if (rx_fifo_reset)
            err_cnt <= 5'd0;
        else if (err_inc && !err_dec)
            err_cnt <= err_cnt + 5'd1;
        else if (err_dec && !err_inc)
            err_cnt <= err_cnt - 5'd1;
    end

    // Idle-time counter; clamps when LCR shrinks the limit below it.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            tmo_cnt <= 10'd0;
        else if (rx_fifo_reset || push_rx_fifo
                 || pop_rx_fifo || rx_fifo_empty)
            tmo_cnt <= 10'd0;
        else if (tmo_cnt > tmo_limit)
            tmo_cnt <= tmo_limit;
        else if (enable && tmo_cnt != tmo_limit)
            tmo_cnt <= tmo_cnt + 10'd1;
    end

    // Character timeout request; pop, FIFO clear or disable drops it.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            rx_timeout_int <= 1'b0;
        else if (rx_fifo_reset || pop_rx_fifo || !IER[0])
            rx_timeout_int <= 1'b0;
        else if (tmo_hit)
            rx_timeout_int <= 1'b1;
    end

    // Trigger-level and line-status requests.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_data_int <= 1'b0;
            rx_ls_int   <= 1'b0;
        end else if (rx_fifo_reset) begin
            rx_data_int <= 1'b0;
            rx_ls_int   <= 1'b0;
        end else begin
            rx_data_int <= IER[0] && (rx_fifo_count >= trig_lvl);
            rx_ls_int   <= IER[2]
                        && (lsr_oe | lsr_pe | lsr_fe | lsr_bi);
        end
    end

endmodule

// File: tb/tb_uart_rx_status.sv
// tb_uart_rx_status: directed stimulus with a queued scoreboard.
// A negedge monitor drains expectations against the DUT outputs.
module tb_uart_rx_status;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  LCR = 8'h03;
    logic [1:0]  FCR_trig = 2'b00;
    logic [2:0]  IER = 3'b000;
    logic        push_rx_fifo = 1'b0;
    logic        pop_rx_fifo = 1'b0;
    logic [4:0]  rx_fifo_count = 5'd0;
    logic        rx_fifo_empty = 1'b1;
    logic        rx_fifo_full = 1'b0;
    logic [10:0] rx_fifo_out = 11'd0;
    logic        parity_error = 1'b0;
    logic        framing_error = 1'b0;
    logic        break_error = 1'b0;
    logic        rx_overrun = 1'b0;
    logic        rx_fifo_reset = 1'b0;
    logic        lsr_read = 1'b0;
    logic        lsr_dr, lsr_oe, lsr_pe, lsr_fe, lsr_bi;
    logic        lsr_fifo_err, rx_data_int;
    logic        rx_timeout_int, rx_ls_int;

    localparam logic [8:0] M_DR   = 9'h100;
    localparam logic [8:0] M_OE   = 9'h080;
    localparam logic [8:0] M_PE   = 9'h040;
    localparam logic [8:0] M_FE   = 9'h020;
    localparam logic [8:0] M_BI   = 9'h010;
    localparam logic [8:0] M_FERR = 9'h008;
    localparam logic [8:0] M_DINT = 9'h004;
    localparam logic [8:0] M_TINT = 9'h002;
    localparam logic [8:0] M_LS   = 9'h001;
    localparam logic [8:0] M_ALL  = 9'h1FF;

    typedef struct {
        string      name;
        logic [8:0] mask;
        logic [8:0] exp;
    } exp_t;

    exp_t        sbq[$];
    logic [10:0] fifo_m[$];
    int          checks = 0;
    int          failures = 0;
    logic [8:0]  outv;

    assign outv = {lsr_dr, lsr_oe, lsr_pe, lsr_fe, lsr_bi,
                   lsr_fifo_err, rx_data_int,
                   rx_timeout_int, rx_ls_int};

    uart_rx_status #(.TIMEOUT_CHARS(4)) dut (
        .PCLK           (PCLK),
        .PRESETn        (PRESETn),
        .enable         (enable),
        .LCR            (LCR),
        .FCR_trig       (FCR_trig),
        .IER            (IER),
        .push_rx_fifo   (push_rx_fifo),
        .pop_rx_fifo    (pop_rx_fifo),
        .rx_fifo_count  (rx_fifo_count),
        .rx_fifo_empty  (rx_fifo_empty),
        .rx_fifo_full   (rx_fifo_full),
        .rx_fifo_out    (rx_fifo_out),
        .parity_error   (parity_error),
        .framing_error  (framing_error),
        .break_error    (break_error),
        .rx_overrun     (rx_overrun),
        .rx_fifo_reset  (rx_fifo_reset),
        .lsr_read       (lsr_read),
        .lsr_dr         (lsr_dr),
        .lsr_oe         (lsr_oe),
        .lsr_pe         (lsr_pe),
        .lsr_fe         (lsr_fe),
        .lsr_bi         (lsr_bi),
        .lsr_fifo_err   (lsr_fifo_err),
        .rx_data_int    (rx_data_int),
        .rx_timeout_int (rx_timeout_int),
        .rx_ls_int      (rx_ls_int)
    );

    always #5 PCLK = ~PCLK;

    // Monitor: compare every queued expectation at the falling edge.
    always @(negedge PCLK) begin
        while (sbq.size() > 0) begin
            exp_t it;
            it = sbq.pop_front();
            checks++;
            if ((outv & it.mask) !== (it.exp & it.mask)) begin
                failures++;
                $display("FAIL %s got=%h exp=%h mask=%h",
                         it.name, outv & it.mask,
                         it.exp & it.mask, it.mask);
            end
        end
    end

    task automatic expect_o(input string n,
                            input logic [8:0] m,
                            input logic [8:0] e);
        exp_t it;
        it.name = n;
        it.mask = m;
        it.exp  = e;
        sbq.push_back(it);
    endtask

    // One clock: apply strobes, then update the FIFO model.
    task automatic tick();
        bit was_full;
        bit was_empty;
        @(posedge PCLK);
        #1;
        was_empty = (fifo_m.size() == 0);
        was_full  = (fifo_m.size() == 16);
        if (rx_fifo_reset) begin
            fifo_m.delete();
        end else begin
            if (pop_rx_fifo && !was_empty)
                fifo_m.delete(0);
            if (push_rx_fifo && !was_full)
                fifo_m.push_back({break_error, parity_error,
                                  framing_error, 8'h00});
        end
        push_rx_fifo  = 1'b0;
        pop_rx_fifo   = 1'b0;
        parity_error  = 1'b0;
        framing_error = 1'b0;
        break_error   = 1'b0;
        rx_overrun    = 1'b0;
        rx_fifo_reset = 1'b0;
        lsr_read      = 1'b0;
        enable        = 1'b0;
        rx_fifo_count = 5'(fifo_m.size());
        rx_fifo_empty = (fifo_m.size() == 0);
        rx_fifo_full  = (fifo_m.size() == 16);
        rx_fifo_out   = (fifo_m.size() == 0) ? 11'd0 : fifo_m[0];
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            enable = 1'b1;
            tick();
            tick();
        end
    endtask

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

    initial begin
        #1 PRESETn = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        expect_o("reset_all", M_ALL, 9'h000);
        @(negedge PCLK);
        #2 PRESETn = 1'b1;
        tick();
        tick();
        expect_o("idle", M_ALL, 9'h000);

        // framing error on first entry
        IER = 3'b100;
        push_rx_fifo = 1; framing_error = 1; tick();
        expect_o("fe_dr_p1", M_DR | M_FE, M_DR);
        tick();
        expect_o("fe_lsr_p2", M_ALL, 9'h128);
        tick();
        expect_o("fe_lsint", M_ALL, 9'h129);
        lsr_read = 1; tick();
        expect_o("fe_read", M_DR | M_FE | M_FERR, M_DR | M_FERR);
        tick();
        expect_o("fe_lsint_clr", M_LS, 9'h000);
        pop_rx_fifo = 1; tick();
        expect_o("fe_pop_ferr", M_FERR, 9'h000);
        tick();
        expect_o("fe_dr_clr", M_DR, 9'h000);

        // trigger level 4
        IER = 3'b001; FCR_trig = 2'b01;
        repeat (3) begin push_rx_fifo = 1; tick(); end
        tick();
        expect_o("trig_3", M_DINT, 9'h000);
        push_rx_fifo = 1; tick();
        expect_o("trig_4_p0", M_DINT, 9'h000);
        tick();
        expect_o("trig_4_p1", M_DINT, M_DINT);
        pop_rx_fifo = 1; tick();
        tick();
        expect_o("trig_pop", M_DINT, 9'h000);
        repeat (3) begin pop_rx_fifo = 1; tick(); end

        // timeout 8N1: 640 ticks
        FCR_trig = 2'b11; LCR = 8'h03;
        push_rx_fifo = 1; tick();
        push_rx_fifo = 1; tick();
        pulses(639);
        expect_o("tmo8_639", M_TINT, 9'h000);
        pulses(1);
        expect_o("tmo8_640", M_TINT, M_TINT);
        pop_rx_fifo = 1; tick();
        expect_o("tmo8_pop", M_TINT, 9'h000);
        pulses(639);
        expect_o("tmo8_re_639", M_TINT, 9'h000);
        pulses(1);
        expect_o("tmo8_re_640", M_TINT, M_TINT);
        IER = 3'b000; tick();
        expect_o("tmo8_ier_off", M_TINT, 9'h000);
        pop_rx_fifo = 1; tick();
        IER = 3'b001;

        // timeout 5-bit, parity, 2 stop: 576 ticks
        LCR = 8'h0C;
        push_rx_fifo = 1; tick();
        pulses(500);
        push_rx_fifo = 1; tick();
        pulses(575);
        expect_o("tmo5_575", M_TINT, 9'h000);
        pulses(1);
        expect_o("tmo5_576", M_TINT, M_TINT);
        pop_rx_fifo = 1; tick();
        pop_rx_fifo = 1; tick();

        // LCR shrinks the limit below a running count
        LCR = 8'h03;
        push_rx_fifo = 1; tick();
        pulses(600);
        expect_o("lcr_600", M_TINT, 9'h000);
        LCR = 8'h0C;
        tick();
        tick();
        expect_o("lcr_shrink", M_TINT, M_TINT);
        pop_rx_fifo = 1; tick();
        LCR = 8'h03;

        // overrun on a full FIFO
        IER = 3'b100;
        repeat (16) begin push_rx_fifo = 1; tick(); end
        push_rx_fifo = 1; rx_overrun = 1; parity_error = 1;
        tick();
        expect_o("ovr_set", M_OE | M_FERR | M_PE, M_OE);
        push_rx_fifo = 1; rx_overrun = 1; parity_error = 1;
        lsr_read = 1; tick();
        expect_o("ovr_read_set", M_OE | M_LS, M_OE | M_LS);
        lsr_read = 1; tick();
        expect_o("ovr_read", M_OE, 9'h000);
        rx_fifo_reset = 1; tick();
        expect_o("ovr_fifo_rst", M_DR | M_FERR | M_LS, 9'h000);

        // simultaneous erroneous push and pop
        IER = 3'b101; FCR_trig = 2'b00;
        push_rx_fifo = 1; parity_error = 1; tick();
        push_rx_fifo = 1; break_error = 1; tick();
        push_rx_fifo = 1; framing_error = 1;
        pop_rx_fifo = 1; tick();
        tick();
        expect_o("sim_after", M_PE | M_FE | M_BI | M_FERR,
                 M_PE | M_BI | M_FERR);
        pop_rx_fifo = 1; tick();
        tick();
        expect_o("sim_pop1", M_FE | M_FERR, M_FE | M_FERR);
        pop_rx_fifo = 1; tick();
        expect_o("sim_pop2", M_FERR, 9'h000);

        // FIFO clear keeps sticky LSR bits
        push_rx_fifo = 1; parity_error = 1; tick();
        push_rx_fifo = 1; tick();
        tick();
        expect_o("rst_pre", M_DR | M_FERR | M_DINT | M_LS,
                 M_DR | M_FERR | M_DINT | M_LS);
        rx_fifo_reset = 1; tick();
        expect_o("fifo_rst", M_ALL, 9'h070);
        lsr_read = 1; tick();
        tick();
        expect_o("lsr_clr", M_ALL, 9'h000);

        // asynchronous reset mid-count
        IER = 3'b001; LCR = 8'h03;
        push_rx_fifo = 1; tick();
        pulses(300);
        expect_o("pre_arst", M_DR | M_DINT, M_DR | M_DINT);
        @(negedge PCLK);
        #1 PRESETn = 1'b0;
        #1;
        expect_o("arst", M_ALL, 9'h000);
        tick();
        tick();
        PRESETn = 1'b1;
        pulses(639);
        expect_o("arst_tmo_639", M_TINT, 9'h000);
        pulses(1);
        expect_o("arst_tmo_640", M_TINT, M_TINT);
        pop_rx_fifo = 1; tick();

        for (int i = 0; i < 10 && sbq.size() != 0; i++)
            @(negedge PCLK);
        #1;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d required=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
